// File: rtl/abc_filter.sv
// -----------------------------------------------------------------------------
// abc_filter
//
// Single-bit glitch filter. The raw level `a` is registered into `a_q`. The
// output `b` follows `a_q` only after `a_q` has disagreed with `b` for
// FILT_CYC consecutive clock samples. Any shorter excursion is discarded, and
// an excursion that ends early leaves no partial count behind.
//
// Parameters:
//   FILT_CYC  number of consecutive samples needed for a level change (1..255)
//
// Ports:
//   clk    in   single clock, all state changes on the rising edge
//   rst_n  in   asynchronous active-low reset (clears a_q, cnt and b)
//   a      in   raw level, synchronous to clk
//   b      out  filtered level, driven directly from a flop
//
// Optional build macro:
//   ABC_SVA_EN  when defined, compiles in concurrent assertions and matching
//               cover properties. Behaviour of the filter is unchanged.
// -----------------------------------------------------------------------------
module abc_filter #(
  parameter int FILT_CYC = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  output logic b
);

  localparam int CNT_W = $clog2(FILT_CYC + 1);

  // Last count value before a level change is committed.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYC - 1);

  logic             a_q;
  logic [CNT_W-1:0] cnt;

  // The counter only advances while the registered input disagrees with the
  // output. A single agreeing sample clears it, so partial counts never leak
  // into a later mismatch. When the count reaches CNT_LAST the new level is
  // taken on this edge, which yields the FILT_CYC-sample requirement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= 1'b0;
      cnt <= '0;
      b   <= 1'b0;
    end else begin
      a_q <= a;
      if (a_q == b) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        b   <= a_q;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef ABC_SVA_EN
  // Shift history of a_q. Bit 0 holds the a_q sample from the previous edge,
  // bit i the sample from i+1 edges back. It lets the properties talk about
  // "the previous FILT_CYC samples" without sequence repetition operators.
  logic [FILT_CYC-1:0] aq_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aq_hist <= '0;
    end else begin
      aq_hist <= (aq_hist << 1) | FILT_CYC'(a_q);
    end
  end

  a_b_known: assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown(b))
    else $error("a_b_known");
  c_b_known: cover property (@(posedge clk) disable iff (!rst_n)
    !$isunknown(b));

  a_rise_qualified: assert property (@(posedge clk) disable iff (!rst_n)
    $rose(b) |-> (&aq_hist))
    else $error("a_rise_qualified");
  c_rise_qualified: cover property (@(posedge clk) disable iff (!rst_n)
    $rose(b) && (&aq_hist));

  a_fall_qualified: assert property (@(posedge clk) disable iff (!rst_n)
    $fell(b) |-> !(|aq_hist))
    else $error("a_fall_qualified");
  c_fall_qualified: cover property (@(posedge clk) disable iff (!rst_n)
    $fell(b) && !(|aq_hist));

  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
    cnt <= CNT_LAST)
    else $error("a_cnt_bound");
  c_cnt_bound: cover property (@(posedge clk) disable iff (!rst_n)
    cnt == CNT_LAST);

  // a_q plus the FILT_CYC history bits make FILT_CYC+1 consecutive samples.
  a_hold_high: assert property (@(posedge clk) disable iff (!rst_n)
    (a_q && (&aq_hist)) |-> b)
    else $error("a_hold_high");
  c_hold_high: cover property (@(posedge clk) disable iff (!rst_n)
    a_q && (&aq_hist) && b);

  a_hold_low: assert property (@(posedge clk) disable iff (!rst_n)
    (!a_q && !(|aq_hist)) |-> !b)
    else $error("a_hold_low");
  c_hold_low: cover property (@(posedge clk) disable iff (!rst_n)
    !a_q && !(|aq_hist) && !b);
`endif

endmodule

// File: tb/tb_abc_filter.sv
// -----------------------------------------------------------------------------
// tb_abc_filter
//
// Drives two filter instances from the same stimulus: one with FILT_CYC=3 and
// one with FILT_CYC=1 (bypass). Expected output levels come from a sliding
// window reference: b takes level L once the last FILT_CYC a_q samples all
// equal L. Expectations are queued as stimulus is applied and popped on the
// following falling edge, half a cycle after the rising edge that produced
// them.
// -----------------------------------------------------------------------------
module tb_abc_filter;

  logic clk;
  logic rst_n;
  logic a;
  logic b3;
  logic b1;

  int total;
  int bad;
  int cyc;

  // Reference state shared by both filter widths
  logic m_aq;
  logic m_b3;
  logic m_b1;
  logic hist3[$];
  logic hist1[$];
  logic exp3[$];
  logic exp1[$];

  abc_filter #(.FILT_CYC(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b3)
  );

  abc_filter #(.FILT_CYC(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends even if something stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Called on a falling edge: compares the outputs produced by the previous
  // rising edge against the queue, applies the new input level, advances the
  // reference for the coming rising edge and waits for the next falling edge.
  task automatic drive_cycle(input logic av);
    logic w;
    logic all3;
    logic all1;
    if (exp3.size() > 0) begin
      w = exp3.pop_front();
      total++;
      if (b3 !== w) begin
        bad++;
        $display("[TB] FAIL sb_b3 cyc=%0d got=%b want=%b", cyc, b3, w);
      end
    end
    if (exp1.size() > 0) begin
      w = exp1.pop_front();
      total++;
      if (b1 !== w) begin
        bad++;
        $display("[TB] FAIL sb_b1 cyc=%0d got=%b want=%b", cyc, b1, w);
      end
    end
    a = av;
    hist3.push_back(m_aq);
    if (hist3.size() > 3) void'(hist3.pop_front());
    hist1.push_back(m_aq);
    if (hist1.size() > 1) void'(hist1.pop_front());
    all3 = (hist3.size() == 3);
    foreach (hist3[i]) if (hist3[i] == m_b3) all3 = 1'b0;
    all1 = (hist1.size() == 1);
    foreach (hist1[i]) if (hist1[i] == m_b1) all1 = 1'b0;
    if (all3) m_b3 = ~m_b3;
    if (all1) m_b1 = ~m_b1;
    m_aq = av;
    exp3.push_back(m_b3);
    exp1.push_back(m_b1);
    cyc++;
    @(negedge clk);
  endtask

  // Called on a falling edge: asserts reset between clock edges, checks it
  // takes effect at once and holds across several rising edges, then
  // releases it on a later falling edge.
  task automatic apply_reset(input logic a_during);
    #1;
    rst_n = 1'b0;
    a     = a_during;
    m_aq  = 1'b0;
    m_b3  = 1'b0;
    m_b1  = 1'b0;
    hist3.delete();
    hist1.delete();
    exp3.delete();
    exp1.delete();
    #1;
    total++;
    if (b3 !== 1'b0 || b1 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rst_async_b got=%b%b want=00", b3, b1);
    end
    total++;
    if (dut3.cnt !== 2'd0 || dut1.cnt !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rst_async_cnt got=%0d/%0d want=0/0", dut3.cnt, dut1.cnt);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      total++;
      if (b3 !== 1'b0 || b1 !== 1'b0 || dut3.cnt !== 2'd0) begin
        bad++;
        $display("[TB] FAIL rst_hold got=b3:%b b1:%b cnt:%0d want=0 0 0", b3, b1, dut3.cnt);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    apply_reset(1'b0);
    repeat (3) drive_cycle(1'b0);
    total++;
    if (b3 !== 1'b0 || b1 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rst_release got=%b%b want=00", b3, b1);
    end
  endtask

  task automatic test_long_high();
    $display("[TB] test_long_high");
    repeat (3) drive_cycle(1'b1);
    total++;
    if (b3 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL long_pre_rise got=%b want=0", b3);
    end
    drive_cycle(1'b1);
    total++;
    if (b3 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL long_rise got=%b want=1", b3);
    end
    repeat (2) drive_cycle(1'b1);
    repeat (3) drive_cycle(1'b0);
    total++;
    if (b3 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL long_pre_fall got=%b want=1", b3);
    end
    drive_cycle(1'b0);
    total++;
    if (b3 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL long_fall got=%b want=0", b3);
    end
    repeat (4) drive_cycle(1'b0);
  endtask

  task automatic test_glitch();
    $display("[TB] test_glitch");
    repeat (2) drive_cycle(1'b1);
    repeat (2) drive_cycle(1'b0);
    total++;
    if (b3 !== 1'b0 || dut3.cnt !== 2'd0) begin
      bad++;
      $display("[TB] FAIL glitch got=b:%b cnt:%0d want=b:0 cnt:0", b3, dut3.cnt);
    end
    repeat (3) drive_cycle(1'b0);
  endtask

  task automatic test_back_to_back();
    int highs;
    highs = 0;
    $display("[TB] test_back_to_back");
    repeat (2) begin
      repeat (6) begin
        drive_cycle(1'b1);
        if (b3 === 1'b1) highs++;
      end
      repeat (6) begin
        drive_cycle(1'b0);
        if (b3 === 1'b1) highs++;
      end
    end
    repeat (4) begin
      drive_cycle(1'b0);
      if (b3 === 1'b1) highs++;
    end
    total++;
    if (highs != 12) begin
      bad++;
      $display("[TB] FAIL b2b_high_cycles got=%0d want=12", highs);
    end
  endtask

  task automatic test_reset_mid_count();
    $display("[TB] test_reset_mid_count");
    repeat (3) drive_cycle(1'b1);
    total++;
    if (dut3.cnt !== 2'd2 || b3 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_pre got=cnt:%0d b:%b want=cnt:2 b:0", dut3.cnt, b3);
    end
    apply_reset(1'b1);
    repeat (3) drive_cycle(1'b1);
    total++;
    if (b3 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_pre_rise got=%b want=0", b3);
    end
    drive_cycle(1'b1);
    total++;
    if (b3 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mid_rise got=%b want=1", b3);
    end
    repeat (5) drive_cycle(1'b0);
  endtask

  task automatic test_bypass();
    logic pat[$];
    logic ah[$];
    $display("[TB] test_bypass");
    for (int i = 0; i < 8; i++) pat.push_back(logic'(i % 2 == 0));
    pat.push_back(1'b0);
    pat.push_back(1'b0);
    pat.push_back(1'b1);
    for (int i = 0; i < 4; i++) pat.push_back(1'b0);
    foreach (pat[i]) begin
      ah.push_back(pat[i]);
      drive_cycle(pat[i]);
      if (ah.size() >= 2) begin
        total++;
        if (b1 !== ah[ah.size()-2]) begin
          bad++;
          $display("[TB] FAIL bypass_delay step=%0d got=%b want=%b", i, b1, ah[ah.size()-2]);
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    m_aq  = 1'b0;
    m_b3  = 1'b0;
    m_b1  = 1'b0;
    rst_n = 1'b0;
    a     = 1'b0;
    @(negedge clk);
    test_reset();
    test_long_high();
    test_glitch();
    test_back_to_back();
    test_reset_mid_count();
    test_bypass();
    repeat (2) drive_cycle(1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
